// File: rtl/ysyx_22041211_pc_pkg.sv
// Shared types for the PC generator: FSM states and redirect-source codes.
// Target alignment width for the default instruction size lives here too.
package ysyx_22041211_pc_pkg;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} state_e;

  typedef enum logic [1:0] {RD_NONE, RD_BR, RD_JMP, RD_CSR} rd_src_e;

  localparam int INST_BYTES_DEF = 4;
  localparam int ALIGN_BITS     = $clog2(INST_BYTES_DEF);

endpackage

// File: rtl/ysyx_22041211_redirect_arb.sv
// Redirect arbiter: picks branch > jmp > csr and aligns the winning target.
// Purely combinational, no backpressure; lower-priority sources are dropped.
module ysyx_22041211_redirect_arb
  import ysyx_22041211_pc_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int ALIGN_W  = ALIGN_BITS
) (
  input  logic                i_br_req,
  input  logic                i_br_flag,
  input  logic [ADDR_LEN-1:0] i_br_tgt,
  input  logic                i_jmp_flag,
  input  logic [ADDR_LEN-1:0] i_jmp_tgt,
  input  logic                i_csr_jmp,
  input  logic [ADDR_LEN-1:0] i_csr_tgt,
  output logic                o_take,
  output logic [ADDR_LEN-1:0] o_tgt,
  output rd_src_e             o_src
);

  localparam logic [ADDR_LEN-1:0] ALIGN_MASK = {ADDR_LEN{1'b1}} << ALIGN_W;

  logic                w_br_take;
  logic [ADDR_LEN-1:0] w_raw_tgt;

  assign w_br_take = i_br_req & i_br_flag;

  always_comb begin
    w_raw_tgt = '0;
    o_src     = RD_NONE;
    if (w_br_take) begin
      w_raw_tgt = i_br_tgt;
      o_src     = RD_BR;
    end else if (i_jmp_flag) begin
      w_raw_tgt = i_jmp_tgt;
      o_src     = RD_JMP;
    end else if (i_csr_jmp) begin
      w_raw_tgt = i_csr_tgt;
      o_src     = RD_CSR;
    end
  end

  assign o_take = w_br_take | i_jmp_flag | i_csr_jmp;
  assign o_tgt  = w_raw_tgt & ALIGN_MASK;

endmodule

// File: rtl/ysyx_22041211_pc_gen.sv
// Fetch-request generator: registered pc/epoch, redirect-to-request latency 1 cycle.
// stall_i only gates new requests; an unaccepted request holds and buffers the newest redirect.
module ysyx_22041211_pc_gen
  import ysyx_22041211_pc_pkg::*;
#(
  parameter int                  ADDR_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] RESET_VAL  = 32'h8000_0000,
  parameter int                  INST_BYTES = 4,
  parameter int                  EPOCH_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_request_i,
  input  logic                branch_flag_i,
  input  logic [ADDR_LEN-1:0] branch_target_i,
  input  logic                jmp_flag_i,
  input  logic [ADDR_LEN-1:0] jmp_target_i,
  input  logic                csr_jmp_i,
  input  logic [ADDR_LEN-1:0] csr_pc_i,
  input  logic                stall_i,
  input  logic                req_ready_i,
  output logic                req_valid_o,
  output logic [ADDR_LEN-1:0] req_addr_o,
  output logic [EPOCH_W-1:0]  req_epoch_o,
  output logic [ADDR_LEN-1:0] pc_o
);

  localparam int IB_BITS = $clog2(INST_BYTES);

  state_e              r_state, w_state_nxt;
  logic [ADDR_LEN-1:0] r_pc, w_pc_nxt, w_pc_plus, w_tgt;
  logic [ADDR_LEN-1:0] r_pend_tgt, w_pend_tgt_nxt;
  logic                r_pend_vld, w_pend_vld_nxt;
  logic [EPOCH_W-1:0]  r_epoch;
  logic                w_take, w_epoch_inc, w_req_vld;
  rd_src_e             w_src;

  ysyx_22041211_redirect_arb #(
    .ADDR_LEN (ADDR_LEN),
    .ALIGN_W  (IB_BITS)
  ) u_arb (
    .i_br_req   (branch_request_i),
    .i_br_flag  (branch_flag_i),
    .i_br_tgt   (branch_target_i),
    .i_jmp_flag (jmp_flag_i),
    .i_jmp_tgt  (jmp_target_i),
    .i_csr_jmp  (csr_jmp_i),
    .i_csr_tgt  (csr_pc_i),
    .o_take     (w_take),
    .o_tgt      (w_tgt),
    .o_src      (w_src)
  );

  assign w_pc_plus = r_pc + ADDR_LEN'(INST_BYTES);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pend_vld_nxt = r_pend_vld;
    w_epoch_inc    = 1'b0;
    w_req_vld      = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
        if (w_take) begin
          w_pc_nxt    = w_tgt;
          w_epoch_inc = 1'b1;
        end
      end
      S_RUN: begin
        w_req_vld = !stall_i;
        if (stall_i || req_ready_i) begin
          if (w_take) begin
            w_pc_nxt    = w_tgt;
            w_epoch_inc = 1'b1;
          end else if (!stall_i) begin
            w_pc_nxt = w_pc_plus;
          end
        end else begin
          // Presented but refused: freeze the request and park any redirect.
          w_state_nxt    = S_HOLD;
          w_pend_vld_nxt = w_take;
          if (w_take) w_pend_tgt_nxt = w_tgt;
        end
      end
      S_HOLD: begin
        w_req_vld = 1'b1;
        if (req_ready_i) begin
          w_state_nxt    = S_RUN;
          w_pend_vld_nxt = 1'b0;
          if (w_take) begin
            w_pc_nxt    = w_tgt;
            w_epoch_inc = 1'b1;
          end else if (r_pend_vld) begin
            w_pc_nxt    = r_pend_tgt;
            w_epoch_inc = 1'b1;
          end else begin
            w_pc_nxt = w_pc_plus;
          end
        end else if (w_take) begin
          w_pend_tgt_nxt = w_tgt;
          w_pend_vld_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VAL;
      r_epoch    <= '0;
      r_pend_tgt <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_epoch    <= r_epoch + EPOCH_W'(w_epoch_inc);
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

  a_src_consistent : assert property (@(posedge clk) disable iff (!rst)
    w_take == (w_src != RD_NONE));

  assign req_valid_o = w_req_vld;
  assign req_addr_o  = r_pc;
  assign req_epoch_o = r_epoch;
  assign pc_o        = r_pc;

endmodule

// File: tb/tb_ysyx_22041211_pc_gen.sv
// Bench for the PC generator: directed scenarios pinned by literals, then random traffic.
// A transaction-level model predicts valid/addr/epoch/pc every cycle.
module tb_ysyx_22041211_pc_gen;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_req, br_flag, jmp, csr, stall, ready;
  logic [31:0] bt, jt, ct;
  logic        req_valid;
  logic [31:0] req_addr, pc;
  logic [1:0]  req_epoch;

  int vectors = 0;
  int miscompares = 0;

  logic        s_valid;
  logic [31:0] s_addr, s_pc;
  logic [1:0]  s_epoch;

  // model: "presented request not yet taken" and a buffered redirect
  bit          m_boot, m_outstanding, m_pend_v;
  logic [31:0] m_pc, m_pend;
  int          m_ep;

  always #5 clk = ~clk;

  ysyx_22041211_pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .branch_request_i (br_req),
    .branch_flag_i    (br_flag),
    .branch_target_i  (bt),
    .jmp_flag_i       (jmp),
    .jmp_target_i     (jt),
    .csr_jmp_i        (csr),
    .csr_pc_i         (ct),
    .stall_i          (stall),
    .req_ready_i      (ready),
    .req_valid_o      (req_valid),
    .req_addr_o       (req_addr),
    .req_epoch_o      (req_epoch),
    .pc_o             (pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_outstanding = 0; m_pend_v = 0; m_pc = RST_PC; m_ep = 0; m_pend = '0;
  endtask

  task automatic model_redirect(input logic [31:0] t);
    m_pc = t;
    m_ep = (m_ep + 1) % 4;
  endtask

  task automatic model_step();
    bit          take, presented;
    logic [31:0] t;
    take = (br_req && br_flag) || jmp || csr;
    t = (br_req && br_flag) ? bt : (jmp ? jt : ct);
    t = t - (t % 4);
    presented = m_outstanding || !stall;
    if (m_boot) begin
      if (take) model_redirect(t);
      m_boot = 0;
    end else if (!presented) begin
      if (take) model_redirect(t);
    end else if (ready) begin
      if (take) model_redirect(t);
      else if (m_outstanding && m_pend_v) model_redirect(m_pend);
      else m_pc = m_pc + 32'd4;
      m_outstanding = 0;
      m_pend_v = 0;
    end else begin
      m_outstanding = 1;
      if (take) begin
        m_pend = t;
        m_pend_v = 1;
      end
    end
  endtask

  task automatic cycle();
    bit exp_v;
    @(negedge clk);
    s_valid = req_valid; s_addr = req_addr; s_epoch = req_epoch; s_pc = pc;
    if (!rst) begin
      chk("valid_rst", 32'(s_valid), 32'd0);
      chk("pc_rst", s_pc, RST_PC);
      chk("epoch_rst", 32'(s_epoch), 32'd0);
    end else begin
      exp_v = !m_boot && (m_outstanding || !stall);
      chk("valid", 32'(s_valid), 32'(exp_v));
      chk("addr", s_addr, m_pc);
      chk("pc", s_pc, m_pc);
      chk("epoch", 32'(s_epoch), 32'(m_ep));
    end
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic clear_redirects();
    br_req = 0; br_flag = 0; jmp = 0; csr = 0;
  endtask

  initial begin
    logic [1:0] ep_seq [4];
    ep_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    rst = 0; stall = 0; ready = 1; bt = '0; jt = '0; ct = '0;
    clear_redirects();
    model_reset();
    #1;
    chk("valid_in_reset", 32'(req_valid), 32'd0);
    cycle(); cycle();
    rst = 1;

    // 1: boot idle cycle then sequential fetch
    cycle(); chk("boot_valid", 32'(s_valid), 32'd0);
    cycle(); chk("seq0", s_addr, 32'h8000_0000); chk("seq0_ep", 32'(s_epoch), 0);
    cycle(); chk("seq1", s_addr, 32'h8000_0004);
    cycle(); chk("seq2", s_addr, 32'h8000_0008); chk("seq2_ep", 32'(s_epoch), 0);

    // 2: all three sources at once, branch wins
    br_req = 1; br_flag = 1; bt = 32'h8000_0100;
    jmp = 1; jt = 32'h8000_0500; csr = 1; ct = 32'h8000_0600;
    cycle(); clear_redirects();
    cycle(); chk("prio_addr", s_addr, 32'h8000_0100); chk("prio_ep", 32'(s_epoch), 1);

    // 3: hold at 8000_0010 with two redirects, newest wins
    jmp = 1; jt = 32'h8000_0010; cycle();
    ready = 0; jt = 32'h8000_0200;
    cycle(); chk("hold1_addr", s_addr, 32'h8000_0010); chk("hold1_v", 32'(s_valid), 1);
    jmp = 0; csr = 1; ct = 32'h8000_0300;
    cycle(); chk("hold2_addr", s_addr, 32'h8000_0010); chk("hold2_ep", 32'(s_epoch), 2);
    csr = 0;
    cycle(); chk("hold3_addr", s_addr, 32'h8000_0010);
    ready = 1;
    cycle(); chk("hold_acc_addr", s_addr, 32'h8000_0010);
    cycle(); chk("pend_addr", s_addr, 32'h8000_0300); chk("pend_ep", 32'(s_epoch), 3);

    // 4: stalled redirect with misaligned target, epoch wraps 3 -> 0
    stall = 1; jmp = 1; jt = 32'h8000_0042;
    cycle(); chk("stall_v0", 32'(s_valid), 0);
    jmp = 0;
    cycle(); chk("stall_v1", 32'(s_valid), 0); chk("stall_pc", s_pc, 32'h8000_0040);
    stall = 0;
    cycle(); chk("align_addr", s_addr, 32'h8000_0040); chk("align_ep", 32'(s_epoch), 0);

    // 5: address wrap and epoch sequence
    jmp = 1; jt = 32'hFFFF_FFFC; cycle(); jmp = 0;
    cycle(); chk("top_addr", s_addr, 32'hFFFF_FFFC);
    cycle(); chk("wrap_addr", s_addr, 32'h0000_0000); chk("wrap_ep", 32'(s_epoch), 1);
    for (int k = 0; k < 4; k++) begin
      jmp = 1; jt = 32'h100 * (k + 1);
      cycle(); chk("ep_seq", 32'(s_epoch), 32'(ep_seq[k]));
    end
    jmp = 0;
    cycle(); chk("ep_seq_end", 32'(s_epoch), 1);

    // 6: reset asserted mid-hold with a redirect pending
    ready = 0; jmp = 1; jt = 32'h8000_0700;
    cycle(); jmp = 0;
    cycle(); chk("pre_rst_v", 32'(s_valid), 1);
    #2 rst = 0;
    #1;
    chk("rst_drop_v", 32'(req_valid), 0);
    chk("rst_drop_pc", pc, RST_PC);
    chk("rst_drop_ep", 32'(req_epoch), 0);
    ready = 1;
    cycle();
    rst = 1;
    cycle(); chk("rst_boot_v", 32'(s_valid), 0);
    cycle(); chk("rst_addr0", s_addr, RST_PC); chk("rst_ep0", 32'(s_epoch), 0);
    cycle(); chk("rst_pend_clr", s_addr, 32'h8000_0004);

    // random traffic with occasional asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      rst     = ($urandom_range(0, 99) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      ready   = ($urandom_range(0, 9) < 7);
      br_req  = ($urandom_range(0, 9) < 3);
      br_flag = ($urandom_range(0, 1) == 1);
      jmp     = ($urandom_range(0, 9) == 0);
      csr     = ($urandom_range(0, 19) == 0);
      bt = $urandom; jt = $urandom; ct = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
